// File: rtl/dcdc_seq_pkg.sv
// Shared types and helpers for the DC-DC bias rail sequencer.
package dcdc_seq_pkg;

  localparam int TIMER_W    = 16;
  localparam int RAIL_IDX_W = 3;
  localparam int MAX_RAILS  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SYNC_ON   = 3'd1,
    RAMP_UP   = 3'd2,
    DWELL     = 3'd3,
    READY     = 3'd4,
    RAMP_DOWN = 3'd5,
    FAULT     = 3'd6
  } seq_state_t;

  // Index of the lowest set bit (0 when none set).
  function automatic logic [RAIL_IDX_W-1:0] lowest_set(input logic [MAX_RAILS-1:0] v);
    logic [RAIL_IDX_W-1:0] idx;
    idx = '0;
    for (int k = MAX_RAILS - 1; k >= 0; k--) begin
      if (v[k]) idx = RAIL_IDX_W'(k);
    end
    return idx;
  endfunction

  // Index of the highest set bit (0 when none set).
  function automatic logic [RAIL_IDX_W-1:0] highest_set(input logic [MAX_RAILS-1:0] v);
    logic [RAIL_IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < MAX_RAILS; k++) begin
      if (v[k]) idx = RAIL_IDX_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dcdc_seq_timer.sv
// Microsecond wait timer: prescaler plus saturating 16-bit us counter.
// The restart cycle itself counts as elapsed cycle 0, so a wait of N us
// raises done in the cycle N*TICK_DIV-1 after restart and the resulting
// registered transition lands exactly N*TICK_DIV cycles after entry.
module dcdc_seq_timer
  import dcdc_seq_pkg::*;
#(
  parameter int TICK_DIV = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart,
  input  logic [TIMER_W-1:0] limit,
  output logic               done
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0]   PRE_FIRST = (TICK_DIV > 1) ? PRE_W'(1) : PRE_W'(0);
  localparam logic [TIMER_W-1:0] US_FIRST  = (TICK_DIV > 1) ? TIMER_W'(0) : TIMER_W'(1);
  localparam logic               ONE_CYCLE = (TICK_DIV == 1);

  logic [PRE_W-1:0]   pre_q;
  logic [TIMER_W-1:0] us_q;
  logic               tick;

  assign tick = (pre_q == PRE_LAST);
  assign done = restart ? (ONE_CYCLE && (limit == TIMER_W'(1)))
                        : (tick && (us_q == limit - TIMER_W'(1)));

  // Prescaler and us counter; restart preloads the count of the entry cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      us_q  <= '0;
    end else if (restart) begin
      pre_q <= PRE_FIRST;
      us_q  <= US_FIRST;
    end else if (tick) begin
      pre_q <= '0;
      if (us_q != '1) us_q <= us_q + TIMER_W'(1);
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

endmodule

// File: rtl/dcdc_seq_ctrl.sv
// DC-DC bias rail power sequencer.
//
// state     | meaning
// IDLE      | all off, waiting for seq_start
// SYNC_ON   | sync clock enabled, settling before first rail
// RAMP_UP   | rail i enabled, waiting for its power-good
// DWELL     | rail i good, dwelling before the next rail
// READY     | all rails up
// RAMP_DOWN | disabling rails highest-first with a delay after each
// FAULT     | everything off, fault latched until fault_clr
module dcdc_seq_ctrl
  import dcdc_seq_pkg::*;
#(
  parameter int NUM_RAILS      = 4,
  parameter int TICK_DIV       = 20,
  parameter int SYNC_SETTLE_US = 100,
  parameter int PG_TIMEOUT_US  = 1000,
  parameter int ON_DWELL_US    = 500,
  parameter int OFF_DELAY_US   = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  seq_start,
  input  logic                  seq_stop,
  input  logic                  fault_clr,
  input  logic [NUM_RAILS-1:0]  pgood,
  output logic                  sync_clk_en,
  output logic [NUM_RAILS-1:0]  rail_en,
  output logic                  ready,
  output logic                  busy,
  output logic                  fault,
  output logic [RAIL_IDX_W-1:0] fault_rail,
  output logic [2:0]            state_o
);

  localparam logic [RAIL_IDX_W-1:0] LAST_IDX = RAIL_IDX_W'(NUM_RAILS - 1);

  seq_state_t            state_q;
  logic [NUM_RAILS-1:0]  pg_meta_q, pg_sync_q, rail_en_q;
  logic [RAIL_IDX_W-1:0] rail_idx_q, fault_rail_q;
  logic                  sync_clk_en_q, ready_q, busy_q, fault_q, restart_q;

  logic [TIMER_W-1:0]    tmr_limit;
  logic                  tmr_done;
  logic [NUM_RAILS-1:0]  idx_onehot, top_onehot, mon_mask, mon_bad;
  logic [RAIL_IDX_W-1:0] top_rail, mon_rail, fault_idx;
  logic                  fault_now, pg_cur;

  // Two-flop synchronizer for the asynchronous power-good inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pg_meta_q <= '0;
      pg_sync_q <= '0;
    end else begin
      pg_meta_q <= pgood;
      pg_sync_q <= pg_meta_q;
    end
  end

  // Wait length for the current state.
  always_comb begin
    tmr_limit = TIMER_W'(1);
    case (state_q)
      SYNC_ON:   tmr_limit = TIMER_W'(SYNC_SETTLE_US);
      RAMP_UP:   tmr_limit = TIMER_W'(PG_TIMEOUT_US);
      DWELL:     tmr_limit = TIMER_W'(ON_DWELL_US);
      RAMP_DOWN: tmr_limit = TIMER_W'(OFF_DELAY_US);
      default:   tmr_limit = TIMER_W'(1);
    endcase
  end

  dcdc_seq_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (restart_q),
    .limit   (tmr_limit),
    .done    (tmr_done)
  );

  assign idx_onehot = NUM_RAILS'(1) << rail_idx_q;
  assign top_rail   = highest_set(MAX_RAILS'(rail_en_q));
  assign top_onehot = NUM_RAILS'(1) << top_rail;
  assign pg_cur     = |(pg_sync_q & idx_onehot);

  // Rails already confirmed good; the rail still ramping is not monitored.
  always_comb begin
    mon_mask = '0;
    case (state_q)
      RAMP_UP:      mon_mask = rail_en_q & ~idx_onehot;
      DWELL, READY: mon_mask = rail_en_q;
      default:      mon_mask = '0;
    endcase
  end

  assign mon_bad  = mon_mask & ~pg_sync_q;
  assign mon_rail = lowest_set(MAX_RAILS'(mon_bad));

  // Fault sources: lost power-good on a monitored rail, or ramp-up timeout.
  always_comb begin
    fault_now = |mon_bad;
    fault_idx = mon_rail;
    if (!(|mon_bad) && (state_q == RAMP_UP) && tmr_done) begin
      fault_now = 1'b1;
      fault_idx = rail_idx_q;
    end
  end

  // Sequencer FSM with registered outputs; restart_q marks each new wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rail_en_q     <= '0;
      rail_idx_q    <= '0;
      fault_rail_q  <= '0;
      sync_clk_en_q <= 1'b0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
      restart_q     <= 1'b0;
    end else begin
      restart_q <= 1'b0;
      if (fault_now) begin
        state_q       <= FAULT;
        rail_en_q     <= '0;
        sync_clk_en_q <= 1'b0;
        ready_q       <= 1'b0;
        busy_q        <= 1'b0;
        fault_q       <= 1'b1;
        fault_rail_q  <= fault_idx;
      end else begin
        case (state_q)
          IDLE: begin
            if (seq_start && !seq_stop) begin
              state_q       <= SYNC_ON;
              sync_clk_en_q <= 1'b1;
              busy_q        <= 1'b1;
              restart_q     <= 1'b1;
            end
          end
          SYNC_ON, RAMP_UP, DWELL, READY: begin
            if (seq_stop) begin
              state_q   <= RAMP_DOWN;
              rail_en_q <= rail_en_q & ~top_onehot;
              ready_q   <= 1'b0;
              busy_q    <= 1'b1;
              restart_q <= 1'b1;
            end else if (state_q == SYNC_ON && tmr_done) begin
              state_q    <= RAMP_UP;
              rail_idx_q <= '0;
              rail_en_q  <= rail_en_q | NUM_RAILS'(1);
              restart_q  <= 1'b1;
            end else if (state_q == RAMP_UP && pg_cur) begin
              state_q   <= DWELL;
              restart_q <= 1'b1;
            end else if (state_q == DWELL && tmr_done) begin
              if (rail_idx_q == LAST_IDX) begin
                state_q <= READY;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q    <= RAMP_UP;
                rail_idx_q <= rail_idx_q + RAIL_IDX_W'(1);
                rail_en_q  <= rail_en_q | (idx_onehot << 1);
                restart_q  <= 1'b1;
              end
            end
          end
          RAMP_DOWN: begin
            if (tmr_done) begin
              if (|rail_en_q) begin
                rail_en_q <= rail_en_q & ~top_onehot;
                restart_q <= 1'b1;
              end else begin
                state_q       <= IDLE;
                sync_clk_en_q <= 1'b0;
                busy_q        <= 1'b0;
              end
            end
          end
          FAULT: begin
            if (fault_clr) begin
              state_q      <= IDLE;
              fault_q      <= 1'b0;
              fault_rail_q <= '0;
            end
          end
          default: begin
            state_q       <= IDLE;
            rail_en_q     <= '0;
            sync_clk_en_q <= 1'b0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sync_clk_en = sync_clk_en_q;
  assign rail_en     = rail_en_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign fault       = fault_q;
  assign fault_rail  = fault_rail_q;
  assign state_o     = state_q;

endmodule
